// File: rtl/erlist_pkg.sv
// Shared Earthrise list definitions: opcode encodings, list read latency and sequencer states.
// Opcode field width (OPW) lives here so the encodings and the decode helpers stay consistent.
package erlist_pkg;

  localparam int unsigned OPW      = 4;
  localparam int unsigned LIST_LAT = 2;

  localparam logic [OPW-1:0] OP_END  = '0;
  localparam logic [OPW-1:0] OP_JUMP = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic op_is_end(input logic [OPW-1:0] op);
    return op == OP_END;
  endfunction

  function automatic logic op_is_jump(input logic [OPW-1:0] op);
    return op == OP_JUMP;
  endfunction

endpackage

// File: rtl/erlist_seq_fifo.sv
// First-word-fall-through prefetch FIFO for the command sequencer.
// Synchronous active-low reset plus a flush that empties it in one cycle.
module erlist_seq_fifo #(
  parameter int unsigned WORD  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WORD-1:0]          din,
  input  logic                     pop,
  output logic [WORD-1:0]          dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WORD-1:0] mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;
  logic [CW-1:0]   count_nx;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && valid;
    do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    count_nx = count;
    if (do_push && !do_pop) begin
      count_nx = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_nx = count - CW'(1);
    end
  end

  assign dout = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_nx;
      valid <= (count_nx != '0);
    end
  end

endmodule

// File: rtl/erlist_seq.sv
// Earthrise command sequencer: prefetches list words over a 2-cycle read port and hands them to the engine.
// Build macro ERLIST_SEQ_JUMP_EN makes the all-ones opcode a JUMP; otherwise it is an ordinary command.
module erlist_seq
  import erlist_pkg::*;
#(
  parameter int unsigned WORD       = 32,
  parameter int unsigned ADDRW      = 9,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDRW-1:0] start_addr,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] addr_er,
  input  logic [WORD-1:0]  dout_er,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [WORD-1:0]  cmd_data,
  output logic [15:0]      cmd_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  state_t              state;
  logic [LIST_LAT-1:0] in_flight;
  logic [CW-1:0]       occ;
  logic [SW-1:0]       pending;
  logic [OPW-1:0]      ret_op;
  logic                ret_valid;
  logic                ret_end;
  logic                ret_jump;
  logic                issue;
  logic                drain_done;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_flush;

  // Return decode and issue throttle: never request more than the FIFO can absorb.
  always_comb begin
    ret_op    = dout_er[WORD-1 -: OPW];
    ret_valid = (state == ST_FETCH) && in_flight[LIST_LAT-1];
    ret_end   = ret_valid && op_is_end(ret_op);
`ifdef ERLIST_SEQ_JUMP_EN
    ret_jump  = ret_valid && op_is_jump(ret_op);
`else
    ret_jump  = 1'b0;
`endif
    pending    = SW'(occ) + SW'($countones(in_flight));
    issue      = (state == ST_FETCH) && !abort && !ret_end && !ret_jump &&
                 (pending < SW'(FIFO_DEPTH));
    fifo_push  = ret_valid && !ret_end && !ret_jump && !abort;
    fifo_pop   = cmd_valid && cmd_ready;
    fifo_flush = abort && (state != ST_IDLE);
    drain_done = (occ == '0) || ((occ == CW'(1)) && fifo_pop);
  end

  erlist_seq_fifo #(
    .WORD  (WORD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (dout_er),
    .pop   (fifo_pop),
    .dout  (cmd_data),
    .valid (cmd_valid),
    .count (occ)
  );

  // Sequencer state, address counter, in-flight tracking and handover count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr_er   <= '0;
      in_flight <= '0;
      cmd_count <= '0;
    end else begin
      done      <= 1'b0;
      in_flight <= {in_flight[LIST_LAT-2:0], issue};
      if (fifo_pop && (cmd_count != 16'hFFFF)) begin
        cmd_count <= cmd_count + 16'd1;
      end
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state     <= ST_FETCH;
            busy      <= 1'b1;
            addr_er   <= start_addr;
            cmd_count <= '0;
          end
        end
        ST_FETCH: begin
          if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            in_flight <= '0;
          end else if (ret_end) begin
            in_flight <= '0;
            if (drain_done) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end else if (ret_jump) begin
            in_flight <= '0;
            addr_er   <= dout_er[ADDRW-1:0];
          end else if (issue) begin
            addr_er <= addr_er + ADDRW'(1);
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (drain_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
